traffic_light_monitor: RTL and testbench

Independent safety monitor at the output end of the traffic controller. It samples the seven lamp drives (main/side G/Y/R plus pedLight) and decodes them back into per-approach phases. It checks encoding, conflicts, transition order and minimum dwell times. On the first violation it latches a fault code and drives a flashing-red override for the board-level lamp mux.

---
 rtl/tl_mon_pkg.sv | 54 +++++
 rtl/tl_mon_if.sv | 22 ++
 rtl/tl_phase_tracker.sv | 87 ++++++++
 rtl/traffic_light_monitor.sv | 172 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_mon_pkg.sv
// Shared phase/state types, fault codes and small decode helpers for the
// traffic-light safety monitor (starvation check gated by TL_MON_STARVE_EN).
package tl_mon_pkg;

    typedef enum logic [1:0] {
        PH_INVALID = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2,
        PH_RED     = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_INVALID   = 3'd1;
    localparam logic [2:0] FC_CONFLICT  = 3'd2;
    localparam logic [2:0] FC_PED       = 3'd3;
    localparam logic [2:0] FC_ILLEGAL   = 3'd4;
    localparam logic [2:0] FC_SHORT_YEL = 3'd5;
    localparam logic [2:0] FC_SHORT_GRN = 3'd6;
    localparam logic [2:0] FC_STARVE    = 3'd7;

    function automatic phase_t decode_phase(input logic g, input logic y, input logic r);
        phase_t ph;
        case ({g, y, r})
            3'b100:  ph = PH_GREEN;
            3'b010:  ph = PH_YELLOW;
            3'b001:  ph = PH_RED;
            default: ph = PH_INVALID;
        endcase
        return ph;
    endfunction

    // Only the forward cycle GREEN -> YELLOW -> RED -> GREEN is a legal step.
    function automatic logic trans_legal(input phase_t from_ph, input phase_t to_ph);
        logic ok;
        case (from_ph)
            PH_GREEN:  ok = (to_ph == PH_YELLOW);
            PH_YELLOW: ok = (to_ph == PH_RED);
            PH_RED:    ok = (to_ph == PH_GREEN);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_go(input phase_t ph);
        return (ph == PH_GREEN) || (ph == PH_YELLOW);
    endfunction

endpackage

// File: rtl/tl_mon_if.sv
// Lamp-drive sampling bus and monitor results for traffic_light_monitor.
interface tl_mon_if;
    logic       MG, MY, MR;
    logic       SG, SY, SR;
    logic       pedLight;
    logic       clear;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_red;
    logic [1:0] mainPhase;
    logic [1:0] sidePhase;

    modport master (
        output MG, MY, MR, SG, SY, SR, pedLight, clear,
        input  fault, fault_code, flash_red, mainPhase, sidePhase
    );

    modport slave (
        input  MG, MY, MR, SG, SY, SR, pedLight, clear,
        output fault, fault_code, flash_red, mainPhase, sidePhase
    );
endinterface

// File: rtl/tl_phase_tracker.sv
// Per-approach lamp decoder with previous-phase and dwell registers; the
// starve output exists only when TL_MON_STARVE_EN is defined.
module tl_phase_tracker
    import tl_mon_pkg::*;
#(
    parameter int MIN_GREEN_CYC  = 5,
    parameter int MIN_YELLOW_CYC = 3,
`ifdef TL_MON_STARVE_EN
    parameter int MAX_RED_CYC    = 60,
`endif
    parameter int CNT_W          = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   g,
    input  logic   y,
    input  logic   r,
    output phase_t phase,
    output phase_t prev_phase,
    output logic   changed,
    output logic   illegal_trans,
    output logic   short_green,
    output logic   short_yellow
`ifdef TL_MON_STARVE_EN
    ,
    output logic   starve
`endif
);

    localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_G_L   = CNT_W'(MIN_GREEN_CYC);
    localparam logic [CNT_W-1:0] MIN_Y_L   = CNT_W'(MIN_YELLOW_CYC);

    phase_t           cur_s;
    phase_t           prev_r;
    logic             changed_s;
    logic [CNT_W-1:0] dwell_r;
    logic [CNT_W-1:0] dwell_nxt_s;

    // Decode the current sample and compute the saturating dwell update.
    always_comb begin
        cur_s     = decode_phase(g, y, r);
        changed_s = (cur_s != prev_r);
        if (changed_s) begin
            dwell_nxt_s = DWELL_ONE;
        end else if (dwell_r == DWELL_MAX) begin
            dwell_nxt_s = DWELL_MAX;
        end else begin
            dwell_nxt_s = dwell_r + DWELL_ONE;
        end
    end

    // Phase history runs in every monitor state, including FAULT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r  <= PH_INVALID;
            dwell_r <= {CNT_W{1'b0}};
        end else begin
            prev_r  <= cur_s;
            dwell_r <= dwell_nxt_s;
        end
    end

    // Pair checks use the dwell of the phase being left; illegal_trans is only
    // meaningful together with changed.
    always_comb begin
        if ((prev_r != PH_INVALID) && (cur_s != PH_INVALID)) begin
            illegal_trans = !trans_legal(prev_r, cur_s);
            short_green   = (prev_r == PH_GREEN) && (cur_s == PH_YELLOW) && (dwell_r < MIN_G_L);
            short_yellow  = (prev_r == PH_YELLOW) && (cur_s == PH_RED) && (dwell_r < MIN_Y_L);
        end else begin
            illegal_trans = 1'b0;
            short_green   = 1'b0;
            short_yellow  = 1'b0;
        end
    end

`ifdef TL_MON_STARVE_EN
    assign starve = (cur_s == PH_RED) && (dwell_nxt_s == CNT_W'(MAX_RED_CYC));
`endif

    assign phase      = cur_s;
    assign prev_phase = prev_r;
    assign changed    = changed_s;

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor on the lamp drives: prioritised fault detection, latched fault
// code and flashing-red override. Code 7 (RED starvation) needs TL_MON_STARVE_EN.
module traffic_light_monitor
    import tl_mon_pkg::*;
#(
    parameter int MIN_GREEN_CYC  = 5,
    parameter int MIN_YELLOW_CYC = 3,
    parameter int MAX_RED_CYC    = 60,
    parameter int FLASH_CYC      = 4,
    parameter int CNT_W          = 8
) (
    input logic   clk,
    input logic   reset,
    tl_mon_if.slave mon
);

    localparam logic [CNT_W-1:0] FLASH_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FLASH_L   = CNT_W'(FLASH_CYC);

    if ((MIN_GREEN_CYC >= (32'd1 << CNT_W)) || (MIN_YELLOW_CYC >= (32'd1 << CNT_W)) ||
        (MAX_RED_CYC >= (32'd1 << CNT_W)) || (FLASH_CYC >= (32'd1 << CNT_W))) begin : g_cfg_check
        $error("traffic_light_monitor: cycle parameter does not fit in CNT_W bits");
    end

    phase_t     m_cur_s, m_prev_s, s_cur_s, s_prev_s;
    logic       m_changed_s, m_illegal_s, m_short_grn_s, m_short_yel_s;
    logic       s_changed_s, s_illegal_s, s_short_grn_s, s_short_yel_s;
    logic       starve_s;
    logic [2:0] code_s;

    mon_state_t       state_r;
    logic             fault_r;
    logic [2:0]       fault_code_r;
    logic             flash_red_r;
    logic [CNT_W-1:0] flash_cnt_r;

`ifdef TL_MON_STARVE_EN
    logic m_starve_s, s_starve_s;
`endif

    tl_phase_tracker #(
        .MIN_GREEN_CYC (MIN_GREEN_CYC),
        .MIN_YELLOW_CYC(MIN_YELLOW_CYC),
`ifdef TL_MON_STARVE_EN
        .MAX_RED_CYC   (MAX_RED_CYC),
`endif
        .CNT_W         (CNT_W)
    ) u_main (
        .clk          (clk),
        .reset        (reset),
        .g            (mon.MG),
        .y            (mon.MY),
        .r            (mon.MR),
        .phase        (m_cur_s),
        .prev_phase   (m_prev_s),
        .changed      (m_changed_s),
        .illegal_trans(m_illegal_s),
        .short_green  (m_short_grn_s),
        .short_yellow (m_short_yel_s)
`ifdef TL_MON_STARVE_EN
        ,
        .starve       (m_starve_s)
`endif
    );

    tl_phase_tracker #(
        .MIN_GREEN_CYC (MIN_GREEN_CYC),
        .MIN_YELLOW_CYC(MIN_YELLOW_CYC),
`ifdef TL_MON_STARVE_EN
        .MAX_RED_CYC   (MAX_RED_CYC),
`endif
        .CNT_W         (CNT_W)
    ) u_side (
        .clk          (clk),
        .reset        (reset),
        .g            (mon.SG),
        .y            (mon.SY),
        .r            (mon.SR),
        .phase        (s_cur_s),
        .prev_phase   (s_prev_s),
        .changed      (s_changed_s),
        .illegal_trans(s_illegal_s),
        .short_green  (s_short_grn_s),
        .short_yellow (s_short_yel_s)
`ifdef TL_MON_STARVE_EN
        ,
        .starve       (s_starve_s)
`endif
    );

`ifdef TL_MON_STARVE_EN
    assign starve_s = m_starve_s || s_starve_s;
`else
    assign starve_s = 1'b0;
`endif

    // Lowest code wins; INIT has no valid history, so only snapshot checks apply.
    always_comb begin
        if ((m_cur_s == PH_INVALID) || (s_cur_s == PH_INVALID)) begin
            code_s = FC_INVALID;
        end else if ((m_cur_s != PH_RED) && (s_cur_s != PH_RED)) begin
            code_s = FC_CONFLICT;
        end else if (mon.pedLight && (is_go(m_cur_s) || is_go(s_cur_s))) begin
            code_s = FC_PED;
        end else if (state_r == ST_INIT) begin
            code_s = FC_NONE;
        end else if ((m_changed_s && m_illegal_s) || (s_changed_s && s_illegal_s)) begin
            code_s = FC_ILLEGAL;
        end else if (m_short_yel_s || s_short_yel_s) begin
            code_s = FC_SHORT_YEL;
        end else if (m_short_grn_s || s_short_grn_s) begin
            code_s = FC_SHORT_GRN;
        end else if (starve_s) begin
            code_s = FC_STARVE;
        end else begin
            code_s = FC_NONE;
        end
    end

    // Monitor state machine with registered fault, code and flash outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_INIT;
            fault_r      <= 1'b0;
            fault_code_r <= FC_NONE;
            flash_red_r  <= 1'b0;
            flash_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT, ST_MONITOR: begin
                    if (code_s != FC_NONE) begin
                        state_r      <= ST_FAULT;
                        fault_r      <= 1'b1;
                        fault_code_r <= code_s;
                        flash_red_r  <= 1'b1;
                        flash_cnt_r  <= FLASH_ONE;
                    end else begin
                        state_r      <= ST_MONITOR;
                    end
                end
                ST_FAULT: begin
                    if (mon.clear) begin
                        state_r      <= ST_INIT;
                        fault_r      <= 1'b0;
                        fault_code_r <= FC_NONE;
                        flash_red_r  <= 1'b0;
                        flash_cnt_r  <= {CNT_W{1'b0}};
                    end else if (flash_cnt_r >= FLASH_L) begin
                        flash_red_r  <= !flash_red_r;
                        flash_cnt_r  <= FLASH_ONE;
                    end else begin
                        flash_cnt_r  <= flash_cnt_r + FLASH_ONE;
                    end
                end
                default: begin
                    state_r      <= ST_INIT;
                    fault_r      <= 1'b0;
                    fault_code_r <= FC_NONE;
                    flash_red_r  <= 1'b0;
                    flash_cnt_r  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign mon.fault      = fault_r;
    assign mon.fault_code = fault_code_r;
    assign mon.flash_red  = flash_red_r;
    assign mon.mainPhase  = m_prev_s;
    assign mon.sidePhase  = s_prev_s;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: vector table, directed corner
// sequences and randomized lamp traffic against a run-length reference model.
module tb_traffic_light_monitor;

    localparam int MIN_G = 5;
    localparam int MIN_Y = 3;
    localparam int MAX_R = 60;
    localparam int FLASH = 4;

    localparam logic [2:0] LG   = 3'b100;
    localparam logic [2:0] LY   = 3'b010;
    localparam logic [2:0] LR   = 3'b001;
    localparam logic [2:0] LOFF = 3'b000;
    localparam logic [2:0] LYR  = 3'b011;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    tl_mon_if bus();

    traffic_light_monitor #(
        .MIN_GREEN_CYC (MIN_G),
        .MIN_YELLOW_CYC(MIN_Y),
        .MAX_RED_CYC   (MAX_R),
        .FLASH_CYC     (FLASH),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mon  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m;
        logic [2:0] s;
        int         reps;
        int         code;
        int         mph;
        int         sph;
    } vec_t;

    vec_t tbl[8];

    // reference model state: phase runs per approach, fault bookkeeping
    int mdl_state;
    int last_ph[2];
    int run_len[2];
    int e_fault, e_code, e_flash, fault_age;
    int drv_ph[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] m, input logic [2:0] s, input logic p, input logic c);
        {bus.MG, bus.MY, bus.MR} = m;
        {bus.SG, bus.SY, bus.SR} = s;
        bus.pedLight = p;
        bus.clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fault(input string name, input int code);
        check({name, ".fault"}, int'(bus.fault), (code != 0) ? 1 : 0);
        check({name, ".code"}, int'(bus.fault_code), code);
    endtask

    task automatic do_clear();
        apply(LR, LR, 1'b0, 1'b1);
        expect_fault("clear", 0);
        check("clear.flash", int'(bus.flash_red), 0);
        apply(LR, LR, 1'b0, 1'b0);
        expect_fault("init", 0);
    endtask

    function automatic int dec(input logic [2:0] b);
        case (b)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] ph_bits(input int ph);
        case (ph)
            1:       return LG;
            2:       return LY;
            3:       return LR;
            default: return LOFF;
        endcase
    endfunction

    task automatic model_reset();
        mdl_state = 0;
        last_ph   = '{0, 0};
        run_len   = '{0, 0};
        e_fault   = 0;
        e_code    = 0;
        e_flash   = 0;
        fault_age = 0;
    endtask

    task automatic model_step(input logic [2:0] m, input logic [2:0] s, input logic p, input logic c);
        int cur[2];
        int nxt_run[2];
        int code;
        cur[0] = dec(m);
        cur[1] = dec(s);
        for (int a = 0; a < 2; a++)
            nxt_run[a] = (cur[a] == last_ph[a]) ? ((run_len[a] < 255) ? run_len[a] + 1 : 255) : 1;
        code = 0;
        if (cur[0] == 0 || cur[1] == 0) code = 1;
        else if (cur[0] != 3 && cur[1] != 3) code = 2;
        else if (p && (cur[0] < 3 || cur[1] < 3)) code = 3;
        else if (mdl_state != 0) begin
            code = 8;
            for (int a = 0; a < 2; a++) begin
                if (cur[a] != last_ph[a] && last_ph[a] != 0) begin
                    if (cur[a] != last_ph[a] % 3 + 1) code = (code < 4) ? code : 4;
                    if (last_ph[a] == 2 && cur[a] == 3 && run_len[a] < MIN_Y) code = (code < 5) ? code : 5;
                    if (last_ph[a] == 1 && cur[a] == 2 && run_len[a] < MIN_G) code = (code < 6) ? code : 6;
                end
`ifdef TL_MON_STARVE_EN
                if (cur[a] == 3 && nxt_run[a] == MAX_R) code = (code < 7) ? code : 7;
`endif
            end
            if (code == 8) code = 0;
        end
        if (mdl_state == 2) begin
            if (c) begin
                mdl_state = 0;
                e_fault = 0;
                e_code  = 0;
                e_flash = 0;
            end else begin
                fault_age++;
                e_flash = ((fault_age / FLASH) % 2 == 0) ? 1 : 0;
            end
        end else if (code != 0) begin
            mdl_state = 2;
            e_fault   = 1;
            e_code    = code;
            e_flash   = 1;
            fault_age = 0;
        end else begin
            mdl_state = 1;
        end
        last_ph = cur;
        run_len = nxt_run;
    endtask

    function automatic int pack_act();
        return {23'd0, bus.fault, bus.fault_code, bus.flash_red, bus.mainPhase, bus.sidePhase};
    endfunction

    function automatic int pack_exp();
        return (e_fault << 8) | (e_code << 5) | (e_flash << 4) | (last_ph[0] << 2) | last_ph[1];
    endfunction

    task automatic rand_cycle(input int n);
        logic [2:0] lamp[2];
        int r;
        logic p, c;
        for (int a = 0; a < 2; a++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10 && (drv_ph[1-a] == 3 || r < 2)) drv_ph[a] = drv_ph[a] % 3 + 1;
            lamp[a] = ph_bits(drv_ph[a]);
            if ($urandom_range(0, 99) < 2) lamp[a] = 3'($urandom_range(0, 7));
        end
        p = ($urandom_range(0, 99) < 5);
        c = ($urandom_range(0, 99) < 15);
        apply(lamp[0], lamp[1], p, c);
        model_step(lamp[0], lamp[1], p, c);
        check($sformatf("rand%0d", n), pack_act(), pack_exp());
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".fault"}, int'(bus.fault), 0);
        check({name, ".code"}, int'(bus.fault_code), 0);
        check({name, ".flash"}, int'(bus.flash_red), 0);
        check({name, ".mph"}, int'(bus.mainPhase), 0);
        check({name, ".sph"}, int'(bus.sidePhase), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{LG, LR, 5, 0, 1, 3};
        tbl[1] = '{LY, LR, 3, 0, 2, 3};
        tbl[2] = '{LR, LR, 1, 0, 3, 3};
        tbl[3] = '{LR, LG, 5, 0, 3, 1};
        tbl[4] = '{LR, LY, 3, 0, 3, 2};
        tbl[5] = '{LR, LR, 1, 0, 3, 3};
        tbl[6] = '{LG, LR, 5, 0, 1, 3};
        tbl[7] = '{LG, LG, 1, 2, 1, 1};

        reset = 1'b0;
        {bus.MG, bus.MY, bus.MR} = LR;
        {bus.SG, bus.SY, bus.SR} = LR;
        bus.pedLight = 1'b0;
        bus.clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // legal cycle ending in a conflict row
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                apply(tbl[i].m, tbl[i].s, 1'b0, 1'b0);
                expect_fault($sformatf("vec%0d_%0d", i, k), tbl[i].code);
                check($sformatf("vec%0d_%0d.flash", i, k), int'(bus.flash_red), (tbl[i].code != 0) ? 1 : 0);
                check($sformatf("vec%0d_%0d.mph", i, k), int'(bus.mainPhase), tbl[i].mph);
                check($sformatf("vec%0d_%0d.sph", i, k), int'(bus.sidePhase), tbl[i].sph);
            end
        end

        // later violation is ignored; clear beats a same-cycle violation
        apply(LOFF, LR, 1'b0, 1'b0);
        expect_fault("hold_code2", 2);
        apply(LOFF, LR, 1'b0, 1'b1);
        expect_fault("clear_wins", 0);
        check("clear_wins.flash", int'(bus.flash_red), 0);
        apply(LR, LR, 1'b0, 1'b0);
        expect_fault("reinit", 0);
        apply(LR, LR, 1'b0, 1'b0);
        expect_fault("remonitor", 0);

        // invalid main pattern, then flash cadence
        apply(LYR, LR, 1'b0, 1'b0);
        expect_fault("invalid", 1);
        check("invalid.flash0", int'(bus.flash_red), 1);
        for (int k = 1; k <= 10; k++) begin
            apply(LR, LR, 1'b0, 1'b0);
            check($sformatf("flash%0d", k), int'(bus.flash_red), ((k / FLASH) % 2 == 0) ? 1 : 0);
        end
        do_clear();

        // yellow held 2 samples
        repeat (5) apply(LG, LR, 1'b0, 1'b0);
        repeat (2) apply(LY, LR, 1'b0, 1'b0);
        expect_fault("pre_short_yel", 0);
        apply(LR, LR, 1'b0, 1'b0);
        expect_fault("short_yel", 5);
        do_clear();

        // green jumps straight to red
        repeat (5) apply(LG, LR, 1'b0, 1'b0);
        apply(LR, LR, 1'b0, 1'b0);
        expect_fault("illegal", 4);
        do_clear();

        // same jump with pedestrian lamp during side green
        repeat (5) apply(LG, LR, 1'b0, 1'b0);
        apply(LR, LG, 1'b1, 1'b0);
        expect_fault("ped_over_illegal", 3);
        do_clear();

        // green held 2 samples
        repeat (2) apply(LG, LR, 1'b0, 1'b0);
        apply(LY, LR, 1'b0, 1'b0);
        expect_fault("short_grn", 6);

        // asynchronous reset while faulted
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;

        // side red starvation
        repeat (59) apply(LG, LR, 1'b0, 1'b0);
        expect_fault("red59", 0);
        apply(LG, LR, 1'b0, 1'b0);
`ifdef TL_MON_STARVE_EN
        expect_fault("red60", 7);
`else
        expect_fault("red60", 0);
`endif

        // randomized traffic against the reference model
        #2;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drv_ph = '{3, 3};
        for (int n = 0; n < 3000; n++) rand_cycle(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
